// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helper for the AES MixColumns datapath.
package aes_pkg;

    typedef logic [31:0]  aes_col_t;
    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } mixseq_state_e;

    localparam int AES_NUM_COLS = 4;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] aes_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mixcolumn.sv
// Single-column AES MixColumns, purely combinational.
// Row 0 is the MSB byte of the column.
module aes_mixcolumn
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0] w_x0, w_x1, w_x2, w_x3;

    assign {w_a0, w_a1, w_a2, w_a3} = i_col;

    assign w_x0 = aes_xtime(w_a0);
    assign w_x1 = aes_xtime(w_a1);
    assign w_x2 = aes_xtime(w_a2);
    assign w_x3 = aes_xtime(w_a3);

    // 3*a is xtime(a) ^ a
    assign o_col[31:24] = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
    assign o_col[23:16] = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
    assign o_col[15:8]  = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
    assign o_col[7:0]   = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/aes_mixcolumns_seq.sv
// Time-multiplexed MixColumns over a 128-bit state: 4/COLS_PER_CYCLE+1 cycles (1 on bypass);
// one state in flight, result held in DONE until out_ready, no accept until then.
module aes_mixcolumns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
        $error("aes_mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] LAST_GRP = 2'(AES_NUM_COLS - COLS_PER_CYCLE);
    localparam logic [1:0] GRP_STEP = 2'(COLS_PER_CYCLE);

    mixseq_state_e r_state, w_state_nxt;
    aes_state_t    r_work, w_work_nxt, w_work_upd;
    logic [1:0]    r_col_cnt, w_col_cnt_nxt;

    aes_col_t w_cols     [AES_NUM_COLS];
    aes_col_t w_cols_nxt [AES_NUM_COLS];
    aes_col_t w_mix_in   [COLS_PER_CYCLE];
    aes_col_t w_mix_out  [COLS_PER_CYCLE];

    always_comb begin
        for (int c = 0; c < AES_NUM_COLS; c++) begin
            w_cols[c] = r_work[127-32*c -: 32];
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
        assign w_mix_in[g] = w_cols[r_col_cnt + 2'(g)];

        aes_mixcolumn u_mix (
            .i_col (w_mix_in[g]),
            .o_col (w_mix_out[g])
        );
    end

    // Write the current group back in place; other columns pass unchanged.
    always_comb begin
        for (int c = 0; c < AES_NUM_COLS; c++) begin
            w_cols_nxt[c] = w_cols[c];
        end
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            w_cols_nxt[r_col_cnt + 2'(g)] = w_mix_out[g];
        end
        w_work_upd = '0;
        for (int c = 0; c < AES_NUM_COLS; c++) begin
            w_work_upd[127-32*c -: 32] = w_cols_nxt[c];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_work_nxt    = r_work;
        w_col_cnt_nxt = r_col_cnt;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_work_nxt    = in_state;
                    w_col_cnt_nxt = 2'd0;
                    w_state_nxt   = in_bypass ? DONE : COMPUTE;
                end
            end
            COMPUTE: begin
                busy       = 1'b1;
                w_work_nxt = w_work_upd;
                if (r_col_cnt == LAST_GRP) begin
                    w_state_nxt = DONE;
                end else begin
                    w_col_cnt_nxt = r_col_cnt + GRP_STEP;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work    <= '0;
            r_col_cnt <= 2'd0;
        end else begin
            r_work    <= w_work_nxt;
            r_col_cnt <= w_col_cnt_nxt;
        end
    end

    assign out_state = r_work;

endmodule

// File: tb/tb_aes_mixcolumns_seq.sv
// Directed and back-to-back checks of aes_mixcolumns_seq at COLS_PER_CYCLE = 1, 2 and 4.
module tb_aes_mixcolumns_seq;

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_state  [3];
    logic         in_bypass [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];
    logic         busy      [3];

    int n_vec;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes_mixcolumns_seq #(.COLS_PER_CYCLE(1)) u_p1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state[0]), .in_bypass(in_bypass[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state[0]), .busy(busy[0])
    );

    aes_mixcolumns_seq #(.COLS_PER_CYCLE(2)) u_p2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state[1]), .in_bypass(in_bypass[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state[1]), .busy(busy[1])
    );

    aes_mixcolumns_seq #(.COLS_PER_CYCLE(4)) u_p4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_state(in_state[2]), .in_bypass(in_bypass[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_state(out_state[2]), .busy(busy[2])
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [31:0] ref_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3,
                a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3,
                a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3),
                gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2)};
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        return {ref_col(s[127:96]), ref_col(s[95:64]), ref_col(s[63:32]), ref_col(s[31:0])};
    endfunction

    // Drive one state into instance k, measure latency and busy cycles, check result.
    task automatic run_xact(input int k, input string tag, input logic [127:0] st, input logic bp,
                            input logic [127:0] exp, input int exp_lat, input int exp_busy);
        int lat;
        int nb;
        @(posedge clk); #1;
        chk({tag, "_in_ready"}, 128'(in_ready[k]), 128'(1));
        in_valid[k]  = 1'b1;
        in_state[k]  = st;
        in_bypass[k] = bp;
        @(posedge clk); #1;
        in_valid[k]  = 1'b0;
        in_state[k]  = '1;
        in_bypass[k] = 1'b0;
        lat = 1;
        nb  = 0;
        while (!out_valid[k] && lat < 64) begin
            if (busy[k]) nb++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_busy_cycles"}, 128'(nb), 128'(exp_busy));
        chk({tag, "_out_state"}, out_state[k], exp);
        if (out_ready[k]) begin
            @(posedge clk); #1;
            chk({tag, "_out_valid_drop"}, 128'(out_valid[k]), 128'(0));
            chk({tag, "_in_ready_back"}, 128'(in_ready[k]), 128'(1));
        end
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] BYP_IN   = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] SWP_IN   = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
    localparam logic [127:0] SWP_OUT  = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;

    logic [127:0] vec [8];

    initial begin
        int p;
        int q;
        int cyc;
        logic acc;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_state[k]  = '0;
            in_bypass[k] = 1'b0;
            out_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_in_ready_%0d", k), 128'(in_ready[k]), 128'(1));
            chk($sformatf("reset_out_valid_%0d", k), 128'(out_valid[k]), 128'(0));
            chk($sformatf("reset_busy_%0d", k), 128'(busy[k]), 128'(0));
            chk($sformatf("reset_out_state_%0d", k), out_state[k], 128'(0));
        end
        rst = 1'b0;

        run_xact(0, "fips_p1", FIPS_IN, 1'b0, FIPS_OUT, 5, 4);
        run_xact(0, "bypass_p1", BYP_IN, 1'b1, BYP_IN, 1, 0);
        run_xact(1, "sweep_p2", SWP_IN, 1'b0, SWP_OUT, 3, 2);
        run_xact(2, "sweep_p4", SWP_IN, 1'b0, SWP_OUT, 2, 1);
        run_xact(2, "bypass_p4", SWP_IN, 1'b1, SWP_IN, 1, 0);

        // Backpressure: hold DONE for 10 cycles.
        out_ready[0] = 1'b0;
        run_xact(0, "bp_p1", SWP_IN, 1'b0, SWP_OUT, 5, 4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_valid_%0d", i), 128'(out_valid[0]), 128'(1));
            chk($sformatf("bp_hold_state_%0d", i), out_state[0], SWP_OUT);
            chk($sformatf("bp_hold_in_ready_%0d", i), 128'(in_ready[0]), 128'(0));
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 128'(out_valid[0]), 128'(0));
        chk("bp_release_in_ready", 128'(in_ready[0]), 128'(1));

        // Reset while column 2 is being processed.
        @(posedge clk); #1;
        in_valid[0] = 1'b1;
        in_state[0] = FIPS_IN;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_busy_before", 128'(busy[0]), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_busy", 128'(busy[0]), 128'(0));
        chk("rst_mid_in_ready", 128'(in_ready[0]), 128'(1));
        chk("rst_mid_out_valid", 128'(out_valid[0]), 128'(0));
        chk("rst_mid_out_state", out_state[0], 128'(0));
        run_xact(0, "after_rst_p1", FIPS_IN, 1'b0, FIPS_OUT, 5, 4);

        // Back-to-back with random downstream stalls.
        for (int i = 0; i < 8; i++) begin
            vec[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        p   = 0;
        q   = 0;
        cyc = 0;
        in_valid[0]  = 1'b1;
        in_state[0]  = vec[0];
        in_bypass[0] = 1'b0;
        out_ready[0] = 1'($urandom_range(0, 1));
        while (q < 8 && cyc < 2000) begin
            @(negedge clk);
            acc = in_valid[0] && in_ready[0];
            if (out_valid[0] && out_ready[0]) begin
                if (q < p) begin
                    chk($sformatf("b2b_%0d", q), out_state[0], ref_state(vec[q]));
                end else begin
                    chk($sformatf("b2b_extra_%0d", q), 128'(q), 128'(p));
                end
                q++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) p++;
            if (p < 8) in_state[0] = vec[p];
            else       in_valid[0] = 1'b0;
            out_ready[0] = 1'($urandom_range(0, 1));
        end
        chk("b2b_count", 128'(q), 128'(8));
        chk("b2b_accepted", 128'(p), 128'(8));
        out_ready[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_no_dup", 128'(out_valid[0]), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_mixcolumns_seq.md
Name: aes_mixcolumns_seq

Overview:
Sequencer that applies AES MixColumns to a full 128-bit state by time-multiplexing a small number of single-column aes_mixcolumn datapaths over the four state columns. It sits between the ShiftRows stage and AddRoundKey in the round pipeline. It uses a valid/ready handshake on both sides. A per-transaction bypass flag supports the final round, which has no MixColumns.

Parameters:
COLS_PER_CYCLE, 1, number of aes_mixcolumn instances (columns processed per cycle); legal values 1, 2, 4; anything else is an elaboration error.

Ports:
clk  input  1  clock; all logic rising-edge.
rst  input  1  reset; synchronous, active-high.
in_valid  input  1  in_state/in_bypass valid.
in_ready  output  1  block can accept a state.
in_state  input  128  state; column c = bits [127-32c -: 32]; byte 0 (row 0) in the MSB of each column.
in_bypass  input  1  1 = pass the state through unchanged (final round).
out_valid  output  1  out_state valid.
out_ready  input  1  downstream accepts out_state.
out_state  output  128  result, same column/byte layout as in_state.
busy  output  1  high in the COMPUTE state.

Behaviour:
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_state = 0, col_cnt = 0.
- Reset dominates every other input in every state. Asserting rst mid-transaction aborts the transaction, and no out_valid pulse occurs for it.
- Accept occurs only in IDLE, on in_valid && in_ready.
- in_ready = (state == IDLE). There is no accept in COMPUTE or DONE, and no overlap of an accept with an output transfer.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE: on accept, register in_state into the working register and set col_cnt = 0.
  - in_bypass = 1: go to DONE.
  - in_bypass = 0: go to COMPUTE.
- COMPUTE: each cycle, columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 pass through the aes_mixcolumn instances and are written back in place; col_cnt += COLS_PER_CYCLE.
  - When the last group (col_cnt == 4-COLS_PER_CYCLE) is written, go to DONE.
  - Columns are processed in ascending order; unprocessed columns are held unchanged.
- DONE: out_valid = 1 and out_state = working register, both held stable until out_ready. On out_valid && out_ready, go to IDLE.
- Latency, counted from the accepting edge to the first cycle with out_valid high:
  - 4/COLS_PER_CYCLE + 1 cycles when bypass = 0 (5 / 3 / 2 for parameter values 1 / 2 / 4).
  - 1 cycle when bypass = 0 is not set (bypass = 1).
- Throughput: one state per (latency + 1) cycles when out_ready is held high.
- col_cnt width = 2 bits. It wraps to 0 only through the IDLE accept, never by arithmetic overflow.
- out_ready while not in DONE is ignored. in_valid while in_ready = 0 is ignored, and the upstream holds the data.
- in_state is sampled only at the accepting edge; later input changes have no effect.

Decomposition:
- Package aes_pkg:
  - typedef aes_col_t (logic [31:0]) and aes_state_t (logic [127:0]).
  - enum mixseq_state_e {IDLE, COMPUTE, DONE}.
  - localparam AES_NUM_COLS = 4.
- Sub-module: a generate loop instantiates the existing aes_mixcolumn leaf COLS_PER_CYCLE times. No new sub-module is needed.

Test Plan:
- FIPS-197 vector, COLS_PER_CYCLE=1: in_state = db135345_f20a225c_01010101_c6c6c6c6, bypass=0, out_ready=1 → out_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6; out_valid first high 5 cycles after the accept; busy high for exactly 4 cycles.
- Bypass: in_state = d4d4d4d5_2d26314c_00000000_ffffffff, bypass=1 → identical out_state 1 cycle after the accept; busy never asserts.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_valid and out_state stable; in_ready=0 throughout; transfer completes on the first out_ready=1; in_ready=1 on the next cycle.
- Parameter sweep COLS_PER_CYCLE=2 and 4 with the input d4d4d4d5_2d26314c_db135345_f20a225c → d5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d; latency 3 and 2 respectively.
- Reset mid-COMPUTE, asserted at col_cnt=2 → next cycle: state IDLE, out_valid=0, in_ready=1, out_state=0; a following transaction produces a correct result.
- Back-to-back: 8 random states with in_valid always high and out_ready randomly toggled → every output matches the reference model, in order, with no drops or duplicates.
